uart_rx_core: RTL and testbench

- Serial UART receiver. Oversamples the asynchronous rx line, deframes start/data/stop bits and presents each received byte on a valid/ready output.
- Sits directly upstream of the RX read buffer stage and feeds its data/valid inputs.
- Baud rate is set at runtime through a divisor register supplied by the APB register block.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_rx_core.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and the
// default frame/baud constants used as parameter defaults.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DIV_WIDTH  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud oversample tick generator, shared by the RX and TX paths.
// Ports:
//   clk, rstn - clock, asynchronous active-low reset
//   div       - tick period minus 1, in clk cycles
//   clear     - holds the counter at 0 and suppresses tick
//   tick      - one-cycle pulse every div+1 cycles
// The divisor is captured while cleared and at each wrap, so a change to div
// only takes effect at the next wrap and can never strand the counter above it.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 clear,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;

    always_comb begin
        tick  = ~clear & (cnt_q == div_q);
        cnt_d = cnt_q + 1'b1;
        div_d = div_q;
        if (clear || tick) begin
            cnt_d = '0;
            div_d = div;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx, deframes start/data/(parity)/stop bits using
// an oversampled tick and presents each byte on a valid/ready output.
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   rx             - asynchronous serial input, idle high
//   rx_en          - receiver enable; low forces the FSM to idle
//   div            - baud tick period minus 1
//   data_o         - received byte, stable while valid_out is high
//   valid_out      - data_o holds an unconsumed byte
//   ready_out      - downstream accepts the byte
//   frame_err      - one-cycle pulse, stop bit sampled low
//   overrun        - one-cycle pulse, byte dropped because output was full
//   busy           - FSM not idle
//   parity_odd     - (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//   parity_err     - (UART_RX_PARITY_EN) one-cycle pulse alongside valid_out rise
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    input  logic                  rx_en,
    input  logic [DIV_WIDTH-1:0]  div,
`ifdef UART_RX_PARITY_EN
    input  logic                  parity_odd,
    output logic                  parity_err,
`endif
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_WIDTH - 1);

    logic [1:0]            sync_q;
    logic                  rx_s;
    logic                  tick;
    uart_state_e           state_q, state_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  stop_ok, stop_bad;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, ferr_q, ovr_q;

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk   (clk),
        .rstn  (rstn),
        .div   (div),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_q;
    // Data plus parity bit must have an odd count of ones for odd parity.
    logic par_mismatch;
    assign par_mismatch = ((^shift_q) ^ par_q) != parity_odd;
`endif

    always_comb begin
        state_d  = state_q;
        scnt_d   = tick ? scnt_q + 1'b1 : scnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (tick && scnt_q == SCNT_MID) state_d = rx_s ? StIdle : StData;
            end
            StData: begin
                if (tick && scnt_q == SCNT_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    scnt_d  = '0;
                    if (bcnt_q == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (tick && scnt_q == SCNT_LAST) begin
                    par_d   = rx_s;
                    state_d = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                // Leave at mid-stop-bit so a back-to-back start edge is caught.
                if (tick && scnt_q == SCNT_LAST) begin
                    stop_ok  = rx_s;
                    stop_bad = ~rx_s;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rx_en) begin
            state_d  = StIdle;
            stop_ok  = 1'b0;
            stop_bad = 1'b0;
        end
        if (state_d != state_q) begin
            scnt_d = '0;
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            ovr_q  <= 1'b0;
            if (stop_ok) begin
                // A same-cycle handshake frees the slot for the new byte.
                if (!valid_q || ready_out) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && ready_out) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= stop_ok & par_mismatch;
        end
    end
    assign parity_err = perr_q;
`endif

    assign data_o    = data_q;
    assign valid_out = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames, a frame-level event model that
// predicts when each byte or error lands, and a per-cycle output comparison.
module tb_uart_rx_core;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_DIV0 = 171;  // 3 + (8 + 16*10) * 1
    localparam int LAT_DIV3 = 675;  // 3 + (8 + 16*10) * 4
`else
    localparam int LAT_DIV0 = 155;  // 3 + (8 + 16*9) * 1
    localparam int LAT_DIV3 = 611;  // 3 + (8 + 16*9) * 4
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic        rx_en = 1'b0;
    logic        ready_out = 1'b0;
    logic [15:0] div = 16'd0;
    logic [7:0]  data_o;
    logic        valid_out, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
    logic        parity_err;
`endif

    uart_rx_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .rx_en     (rx_en),
        .div       (div),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
        .parity_err(parity_err),
`endif
        .data_o    (data_o),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected frame outcome: at = edge count after which the result is visible.
    typedef struct {
        int       at;
        bit       ok;
        bit [7:0] data;
        bit       perr;
    } ev_t;
    ev_t evq[$];

    bit [7:0] m_data = 8'h00;
    bit       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            m_perr  <= 1'b0;
            evq.delete();
        end else begin
            m_ferr <= 1'b0;
            m_ovr  <= 1'b0;
            m_perr <= 1'b0;
            if (evq.size() > 0 && evq[0].at == cyc + 1) begin
                if (evq[0].ok) begin
                    if (!m_valid || ready_out) begin
                        m_data  <= evq[0].data;
                        m_valid <= 1'b1;
                    end else begin
                        m_ovr <= 1'b1;
                    end
                    m_perr <= evq[0].perr;
                end else begin
                    m_ferr <= 1'b1;
                end
                void'(evq.pop_front());
            end else if (m_valid && ready_out) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison plus pulse statistics for the literal checks.
    int  n_vhigh = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, vrise_cyc = 0;
    logic [7:0] cap_data = 8'h00;
    logic v_prev = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            check("data_o", {24'd0, data_o}, {24'd0, m_data});
            check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
            check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef UART_RX_PARITY_EN
            check("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
            if (parity_err) n_perr++;
`endif
            if (valid_out && !v_prev) vrise_cyc = cyc;
            if (valid_out) begin
                n_vhigh++;
                cap_data = data_o;
            end
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
        end
        v_prev = valid_out;
    end

    int b_vhigh, b_ferr, b_ovr, b_perr, last_n0;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_vhigh = n_vhigh;
        b_ferr  = n_ferr;
        b_ovr   = n_ovr;
        b_perr  = n_perr;
    endtask

    // par < 0 sends the correct parity bit; abort_at >= 0 resets mid-bit.
    task automatic send(input logic [7:0] d, input bit stop, input int par, input int abort_at);
        logic [10:0] bits;
        int nb, p;
        bit pbit, exp_par;
        p = OS * (int'(div) + 1);
`ifdef UART_RX_PARITY_EN
        exp_par = (^d) ^ parity_odd;
        pbit = (par < 0) ? exp_par : par[0];
        bits = {stop, pbit, d, 1'b0};
        nb = 11;
`else
        exp_par = 1'b0;
        pbit = 1'b0;
        bits = {1'b0, stop, d, 1'b0};
        nb = 10;
`endif
        last_n0 = cyc;
        // Sync (2) + idle detect (1), half a start bit, then the remaining bits.
        evq.push_back('{at: cyc + 3 + (OS / 2 + OS * (nb - 1)) * (int'(div) + 1),
                        ok: stop, data: d, perr: (pbit != exp_par)});
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            if (i == abort_at) begin
                cycles(p / 2);
                rstn = 1'b0;
                cycles(3);
                rx = 1'b1;
                rstn = 1'b1;
                return;
            end
            cycles(p);
        end
        rx = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        check("reset data_o", {24'd0, data_o}, 32'h0);
        check("reset valid_out", {31'd0, valid_out}, 32'h0);
        check("reset frame_err", {31'd0, frame_err}, 32'h0);
        check("reset overrun", {31'd0, overrun}, 32'h0);
        check("reset busy", {31'd0, busy}, 32'h0);
        rstn = 1'b1;
        rx_en = 1'b1;
        ready_out = 1'b1;
        cycles(5);

        // Clean byte, div = 0.
        snap();
        send(8'hA5, 1'b1, -1, -1);
        cycles(20);
        check("a5 data", {24'd0, cap_data}, 32'hA5);
        check("a5 valid cycles", n_vhigh - b_vhigh, 1);
        check("a5 latency", vrise_cyc - last_n0, LAT_DIV0);
        check("a5 ferr", n_ferr - b_ferr, 0);
        check("a5 ovr", n_ovr - b_ovr, 0);
        check("a5 idle", {31'd0, busy}, 32'h0);

        // Start glitch of 4 cycles.
        snap();
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(3);
        check("glitch busy", {31'd0, busy}, 32'h1);
        cycles(20);
        check("glitch idle", {31'd0, busy}, 32'h0);
        check("glitch valid", n_vhigh - b_vhigh, 0);
        check("glitch ferr", n_ferr - b_ferr, 0);

        // Bad stop bit, then a good byte.
        snap();
        send(8'h3C, 1'b0, -1, -1);
        cycles(20);
        check("3c ferr", n_ferr - b_ferr, 1);
        check("3c valid", n_vhigh - b_vhigh, 0);
        send(8'h55, 1'b1, -1, -1);
        cycles(20);
        check("55 data", {24'd0, cap_data}, 32'h55);
        check("55 valid cycles", n_vhigh - b_vhigh, 1);

        // Overrun: two back-to-back bytes with no consumer.
        snap();
        ready_out = 1'b0;
        send(8'h12, 1'b1, -1, -1);
        send(8'h34, 1'b1, -1, -1);
        cycles(20);
        check("ovr count", n_ovr - b_ovr, 1);
        check("ovr data kept", {24'd0, data_o}, 32'h12);
        check("ovr valid held", {31'd0, valid_out}, 32'h1);
        ready_out = 1'b1;
        cycles(1);
        check("ovr valid drop", {31'd0, valid_out}, 32'h0);

        // Receiver disabled mid-frame.
        snap();
        rx = 1'b0;
        cycles(40);
        check("en busy", {31'd0, busy}, 32'h1);
        rx_en = 1'b0;
        cycles(1);
        check("en drop idle", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        cycles(4);
        rx_en = 1'b1;
        cycles(200);
        check("en no byte", n_vhigh - b_vhigh, 0);

        // Reset during data bit 3 at div = 3, then a clean byte.
        div = 16'd3;
        cycles(2);
        send(8'hFF, 1'b1, -1, 4);
        check("rst valid", {31'd0, valid_out}, 32'h0);
        check("rst busy", {31'd0, busy}, 32'h0);
        cycles(5);
        snap();
        send(8'h81, 1'b1, -1, -1);
        cycles(80);
        check("81 data", {24'd0, cap_data}, 32'h81);
        check("81 valid cycles", n_vhigh - b_vhigh, 1);
        check("81 latency", vrise_cyc - last_n0, LAT_DIV3);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        div = 16'd0;
        parity_odd = 1'b0;
        cycles(2);
        snap();
        send(8'h07, 1'b1, 0, -1);
        cycles(20);
        check("par bad data", {24'd0, cap_data}, 32'h07);
        check("par bad perr", n_perr - b_perr, 1);
        snap();
        send(8'h07, 1'b1, 1, -1);
        cycles(20);
        check("par good perr", n_perr - b_perr, 0);
        check("par good valid", n_vhigh - b_vhigh, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
